// File: rtl/rx_pwr_seq_pkg.sv
// Shared types and defaults for the RX power-up / calibration sequencer.
package rx_seq_pkg;

    localparam int unsigned STATE_W         = 3;
    localparam int unsigned SETTLE_CYC_DEF  = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam int unsigned CNT_W_DEF       = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF         = 3'd0,
        ST_IREF_SETTLE = 3'd1,
        ST_IREF_CAL    = 3'd2,
        ST_SUB_SETTLE  = 3'd3,
        ST_SUB_CAL     = 3'd4,
        ST_READY       = 3'd5,
        ST_FAIL        = 3'd6
    } seq_state_e;

    // Registered control outputs toward the top level and the RX macros.
    typedef struct packed {
        logic rdy_rx;
        logic err_rx;
        logic pu_iref;
        logic cal_iref;
        logic pu_bpf;
        logic cal_bpf;
        logic pu_synt;
        logic cal_synt;
    } seq_out_t;

endpackage

// File: rtl/rx_pwr_seq_if.sv
// Control/status bundle between the sequencer, the RX enable and the IREF/BPF/SYNT macros.
interface rx_pwr_seq_if;
    import rx_seq_pkg::*;

    logic               pu_rx;
    logic               rdy_rx;
    logic               err_rx;
    logic               pu_iref;
    logic               cal_iref;
    logic               rdy_iref;
    logic               pu_bpf;
    logic               cal_bpf;
    logic               rdy_bpf;
    logic               pu_synt;
    logic               cal_synt;
    logic               rdy_synt;
    logic [STATE_W-1:0] state;

    modport master (
        input  pu_rx, rdy_iref, rdy_bpf, rdy_synt,
        output rdy_rx, err_rx, pu_iref, cal_iref, pu_bpf, cal_bpf,
               pu_synt, cal_synt, state
    );

    modport slave (
        output pu_rx, rdy_iref, rdy_bpf, rdy_synt,
        input  rdy_rx, err_rx, pu_iref, cal_iref, pu_bpf, cal_bpf,
               pu_synt, cal_synt, state
    );

endinterface

// File: rtl/rx_pwr_seq_timer.sv
// Up counter with synchronous clear; flags when the count equals the terminal value.
module seq_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_i,
    output logic             tc_hit_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_hit_c_o = (cnt_q == tc_i);

    // Holds at the terminal value so a late state exit can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_hit_c_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_pwr_seq.sv
// Ordered RX bring-up: IREF settle/cal, then BPF and SYNT settle/cal in parallel, then READY.
module rx_pwr_seq
    import rx_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rx_pwr_seq_if.master  seq_if
);

    seq_state_e state_q, state_d;
    seq_out_t   out_q, out_d;
    logic       done_bpf_q, done_bpf_d;
    logic       done_synt_q, done_synt_d;

    logic settle_hit_c;
    logic cal_hit_c;
    logic state_chg_c;
    logic settle_en_c;
    logic cal_en_c;
    logic bpf_ok_c;
    logic synt_ok_c;
    logic all_rdy_c;

    assign state_chg_c = (state_d != state_q);
    assign settle_en_c = (state_q == ST_IREF_SETTLE) || (state_q == ST_SUB_SETTLE);
    assign cal_en_c    = (state_q == ST_IREF_CAL) || (state_q == ST_SUB_CAL);
    assign bpf_ok_c    = done_bpf_q || seq_if.rdy_bpf;
    assign synt_ok_c   = done_synt_q || seq_if.rdy_synt;
    assign all_rdy_c   = seq_if.rdy_iref && seq_if.rdy_bpf && seq_if.rdy_synt;

    // Both timers restart on every state change, so each phase counts from its own entry edge.
    seq_timer #(.CNT_W(CNT_W)) u_settle_tmr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (state_chg_c),
        .en_i       (settle_en_c),
        .tc_i       (CNT_W'(SETTLE_CYC - 1)),
        .tc_hit_c_o (settle_hit_c)
    );

    seq_timer #(.CNT_W(CNT_W)) u_cal_tmr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (state_chg_c),
        .en_i       (cal_en_c),
        .tc_i       (CNT_W'(TIMEOUT_CYC - 1)),
        .tc_hit_c_o (cal_hit_c)
    );

    // Next state, done latches and next output values; completion is tested before timeout.
    always_comb begin
        state_d     = state_q;
        done_bpf_d  = 1'b0;
        done_synt_d = 1'b0;
        out_d       = '0;

        if (!seq_if.pu_rx) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:         state_d = ST_IREF_SETTLE;
                ST_IREF_SETTLE: if (settle_hit_c) state_d = ST_IREF_CAL;
                ST_IREF_CAL: begin
                    if (seq_if.rdy_iref)  state_d = ST_SUB_SETTLE;
                    else if (cal_hit_c)   state_d = ST_FAIL;
                end
                ST_SUB_SETTLE:  if (settle_hit_c) state_d = ST_SUB_CAL;
                ST_SUB_CAL: begin
                    if (bpf_ok_c && synt_ok_c) state_d = ST_READY;
                    else if (cal_hit_c)        state_d = ST_FAIL;
                end
                ST_READY:       if (!all_rdy_c) state_d = ST_FAIL;
                ST_FAIL:        state_d = ST_FAIL;
                default:        state_d = ST_OFF;
            endcase
        end

        if ((state_q == ST_SUB_CAL) && (state_d == ST_SUB_CAL)) begin
            done_bpf_d  = bpf_ok_c;
            done_synt_d = synt_ok_c;
        end

        case (state_d)
            ST_IREF_SETTLE: out_d.pu_iref = 1'b1;
            ST_IREF_CAL: begin
                out_d.pu_iref  = 1'b1;
                out_d.cal_iref = 1'b1;
            end
            ST_SUB_SETTLE: begin
                out_d.pu_iref = 1'b1;
                out_d.pu_bpf  = 1'b1;
                out_d.pu_synt = 1'b1;
            end
            ST_SUB_CAL: begin
                out_d.pu_iref  = 1'b1;
                out_d.pu_bpf   = 1'b1;
                out_d.pu_synt  = 1'b1;
                out_d.cal_bpf  = !done_bpf_d;
                out_d.cal_synt = !done_synt_d;
            end
            ST_READY: begin
                out_d.rdy_rx  = 1'b1;
                out_d.pu_iref = 1'b1;
                out_d.pu_bpf  = 1'b1;
                out_d.pu_synt = 1'b1;
            end
            ST_FAIL:        out_d.err_rx = 1'b1;
            default:        out_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_OFF;
            out_q       <= '0;
            done_bpf_q  <= 1'b0;
            done_synt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            done_bpf_q  <= done_bpf_d;
            done_synt_q <= done_synt_d;
        end
    end

    assign seq_if.rdy_rx   = out_q.rdy_rx;
    assign seq_if.err_rx   = out_q.err_rx;
    assign seq_if.pu_iref  = out_q.pu_iref;
    assign seq_if.cal_iref = out_q.cal_iref;
    assign seq_if.pu_bpf   = out_q.pu_bpf;
    assign seq_if.cal_bpf  = out_q.cal_bpf;
    assign seq_if.pu_synt  = out_q.pu_synt;
    assign seq_if.cal_synt = out_q.cal_synt;
    assign seq_if.state    = state_q;

endmodule

// File: tb/tb_rx_pwr_seq.sv
// Bench for rx_pwr_seq: directed and randomized RDY timings against a timeline model.
module tb_rx_pwr_seq;

    localparam int S     = 4;
    localparam int T     = 16;
    localparam int NEVER = 1000000;

    logic clk = 1'b0;
    logic rst;

    rx_pwr_seq_if bus ();

    rx_pwr_seq #(
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (T),
        .CNT_W       (8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .seq_if (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Phase timeline of one bring-up, in edges counted from the PU_RX sampling edge 0.
    int tci, tss, tsc, eb, es, t_ready, t_fail;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // ri/rb/rs: first edge at which each RDY is sampled high.
    task automatic plan(input int ri, input int rb, input int rs);
        int ei;
        tci = S;
        ei  = imax(tci + 1, ri);
        tss = NEVER; tsc = NEVER; eb = NEVER; es = NEVER;
        t_ready = NEVER; t_fail = NEVER;
        if (ei - tci > T) begin
            t_fail = tci + T;
        end else begin
            tss = ei;
            tsc = ei + S;
            eb  = imax(tsc + 1, rb);
            es  = imax(tsc + 1, rs);
            if (imax(eb, es) - tsc <= T) t_ready = imax(eb, es);
            else                         t_fail  = tsc + T;
        end
    endtask

    // {state, rdy_rx, err_rx, pu_iref, cal_iref, pu_bpf, cal_bpf, pu_synt, cal_synt}
    function automatic logic [11:0] expect_vec(input int n);
        logic [2:0] st;
        logic rr, er, pi, ci, pb, cb, ps, cs;
        {rr, er, pi, ci, pb, cb, ps, cs} = 8'b0;
        if (n >= t_fail) begin
            st = 3'd6; er = 1'b1;
        end else if (n >= t_ready) begin
            st = 3'd5; rr = 1'b1; pi = 1'b1; pb = 1'b1; ps = 1'b1;
        end else if (n >= tsc) begin
            st = 3'd4; pi = 1'b1; pb = 1'b1; ps = 1'b1;
            cb = (n < eb); cs = (n < es);
        end else if (n >= tss) begin
            st = 3'd3; pi = 1'b1; pb = 1'b1; ps = 1'b1;
        end else if (n >= tci) begin
            st = 3'd2; pi = 1'b1; ci = 1'b1;
        end else begin
            st = 3'd1; pi = 1'b1;
        end
        return {st, rr, er, pi, ci, pb, cb, ps, cs};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus.state, bus.rdy_rx, bus.err_rx, bus.pu_iref, bus.cal_iref,
                bus.pu_bpf, bus.cal_bpf, bus.pu_synt, bus.cal_synt};
    endfunction

    task automatic check(input string tag, input int n, input logic [11:0] obs,
                         input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s edge %0d: observed %03h expected %03h", tag, n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the DUT in OFF; runs ncyc edges (auto length if ncyc <= 0).
    task automatic run_scenario(input string tag, input int ri, input int rb, input int rs,
                                input int ncyc, output int first_rdy, output int first_err);
        int n_run;
        plan(ri, rb, rs);
        n_run = (ncyc > 0) ? ncyc : imin(t_ready, t_fail) + 4;
        first_rdy = -1;
        first_err = -1;
        bus.pu_rx = 1'b1;
        for (int n = 0; n < n_run; n++) begin
            bus.rdy_iref = (n >= ri);
            bus.rdy_bpf  = (n >= rb);
            bus.rdy_synt = (n >= rs);
            @(posedge clk);
            @(negedge clk);
            check(tag, n, dut_vec(), expect_vec(n));
            if (first_rdy < 0 && bus.rdy_rx === 1'b1) first_rdy = n;
            if (first_err < 0 && bus.err_rx === 1'b1) first_err = n;
        end
    endtask

    task automatic go_off(input string tag);
        bus.pu_rx    = 1'b0;
        bus.rdy_iref = 1'b0;
        bus.rdy_bpf  = 1'b0;
        bus.rdy_synt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(tag, 0, dut_vec(), 12'h000);
    endtask

    initial begin
        int fr, fe;

        rst          = 1'b1;
        bus.pu_rx    = 1'b1;
        bus.rdy_iref = 1'b0;
        bus.rdy_bpf  = 1'b0;
        bus.rdy_synt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_over_pu", 0, dut_vec(), 12'h000);
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", 1, dut_vec(), 12'h000);
        rst       = 1'b0;
        bus.pu_rx = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("off_idle", 0, dut_vec(), 12'h000);

        // Nominal: each RDY answers one cycle after its CAL rises.
        run_scenario("nominal", S + 1, 2 * S + 2, 2 * S + 2, 14, fr, fe);
        check_int("nominal_rdy_edge", fr, 2 * S + 2);
        check_int("nominal_no_err", fe, -1);

        // Runtime loss of RDY_BPF while READY.
        bus.rdy_bpf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_loss", 0, dut_vec(), {3'd6, 1'b0, 1'b1, 6'b0});
        go_off("after_loss");

        run_scenario("staggered", S + 1, 2 * S + 3, 2 * S + 8, 20, fr, fe);
        check_int("staggered_rdy_edge", fr, 2 * S + 8);
        go_off("staggered_off");

        run_scenario("iref_timeout", NEVER, NEVER, NEVER, S + T + 6, fr, fe);
        check_int("iref_timeout_edge", fe, S + T);
        check_int("iref_timeout_no_rdy", fr, -1);
        go_off("iref_timeout_off");

        run_scenario("iref_rdy_at_expiry", S + T, 0, 0, 0, fr, fe);
        check_int("iref_rdy_at_expiry_edge", fr, 2 * S + T + 1);
        go_off("iref_rdy_at_expiry_off");

        run_scenario("iref_rdy_late", S + T + 1, 0, 0, 0, fr, fe);
        check_int("iref_rdy_late_edge", fe, S + T);
        go_off("iref_rdy_late_off");

        run_scenario("synt_at_expiry", S + 1, 2 * S + 3, 2 * S + 1 + T, 0, fr, fe);
        check_int("synt_at_expiry_edge", fr, 2 * S + 1 + T);
        go_off("synt_at_expiry_off");

        run_scenario("synt_late", S + 1, 2 * S + 3, 2 * S + 2 + T, 0, fr, fe);
        check_int("synt_late_edge", fe, 2 * S + 1 + T);
        go_off("synt_late_off");

        run_scenario("rdy_pre_high", 1, 1, 1, 0, fr, fe);
        check_int("rdy_pre_high_edge", fr, 2 * S + 2);
        go_off("rdy_pre_high_off");

        // Abort in SUB_SETTLE, then restart from scratch.
        run_scenario("abort_pre", S + 1, 2 * S + 2, 2 * S + 2, S + 3, fr, fe);
        go_off("abort");
        run_scenario("restart", S + 1, 2 * S + 2, 2 * S + 2, 14, fr, fe);
        check_int("restart_rdy_edge", fr, 2 * S + 2);
        go_off("restart_off");

        // Reset mid-sequence while PU_RX is still requested.
        run_scenario("rst_pre", S + 1, 2 * S + 3, 2 * S + 8, 12, fr, fe);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid", 0, dut_vec(), 12'h000);
        rst = 1'b0;
        go_off("rst_release");

        for (int k = 0; k < 10; k++) begin
            int ri_r, rb_r, rs_r, c0;
            ri_r = int'($urandom_range(1, S + T + 2));
            c0   = imax(S + 1, ri_r) + S;
            rb_r = c0 - 2 + int'($urandom_range(0, T + 3));
            rs_r = c0 - 2 + int'($urandom_range(0, T + 3));
            run_scenario($sformatf("rand%0d", k), ri_r, rb_r, rs_r, 0, fr, fe);
            go_off($sformatf("rand%0d_off", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
